// File: rtl/vga_scan_scheduler.sv
// vga_scan_scheduler
// Generates the 640x480@60 raster (pixel divider, row/col counters, frame
// bookkeeping). It also grants the game logic framebuffer write access at
// most once per frame. Access is granted only during vertical blanking, so
// updates never tear the visible image.

module vga_scan_scheduler #(
  parameter int DIV       = 2,
  parameter int H_TOTAL   = 800,
  parameter int V_TOTAL   = 525,
  parameter int V_VISIBLE = 480
) (
  input  logic       clk,
  input  logic       reset_n,
  output logic [9:0] row,
  output logic [9:0] col,
  output logic       pix_en,
  output logic       frame_start,
  output logic [7:0] frame_count,
  input  logic       upd_req,
  output logic       upd_grant,
  output logic       upd_abort
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    DONE  = 2'd2
  } sched_state_e;

  localparam logic [3:0] DIV_LAST = 4'(DIV - 1);
  localparam logic [9:0] ROW_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] COL_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] COL_VIS  = 10'(V_VISIBLE);

  logic [3:0]   div_cnt;
  logic         row_last;
  logic         col_last;
  logic         end_of_frame;
  logic         vblank;
  sched_state_e state;
  sched_state_e state_next;

  // Raster position decode shared by the counters and the scheduler
  always_comb begin
    row_last     = (row == ROW_LAST);
    col_last     = (col == COL_LAST);
    end_of_frame = pix_en & row_last & col_last;
    vblank       = (col >= COL_VIS);
  end

  // Pixel divider: pix_en is a registered pulse on the clock the divider wraps
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
      pix_en  <= 1'b0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
      pix_en  <= 1'b1;
    end else begin
      div_cnt <= div_cnt + 4'd1;
      pix_en  <= 1'b0;
    end
  end

  // Horizontal/vertical counters advance only on pixel enables
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      row <= '0;
      col <= '0;
    end else if (pix_en) begin
      if (row_last) begin
        row <= '0;
        if (col_last) begin
          col <= '0;
        end else begin
          col <= col + 10'd1;
        end
      end else begin
        row <= row + 10'd1;
      end
    end
  end

  // Frame bookkeeping: frame_start marks the first clock at 0,0 after a wrap
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_start <= 1'b0;
      frame_count <= '0;
    end else begin
      frame_start <= end_of_frame;
      if (end_of_frame) begin
        frame_count <= frame_count + 8'd1;
      end
    end
  end

  // Scheduler state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Scheduler next state: end of frame always wins over a release
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (upd_req && vblank && !end_of_frame) begin
          state_next = GRANT;
        end
      end
      GRANT: begin
        if (end_of_frame) begin
          state_next = IDLE;
        end else if (!upd_req) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (end_of_frame) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Scheduler outputs: grant is a pure state decode so reset drops it at once
  always_comb begin
    upd_grant = (state == GRANT);
  end

  // Abort pulse for a grant still held when the frame wraps
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      upd_abort <= 1'b0;
    end else begin
      upd_abort <= (state == GRANT) && end_of_frame;
    end
  end

endmodule
